dram_ctrl: RTL and testbench
============================

Name: dram_ctrl

Overview:
- Initiator-side controller for the off-chip DRAM model. It drives DRAM_CSn/RASn/CASn/WEn/A/D and samples DRAM_Q.
- Accepts single-word read/write requests from the memory-side bus wrapper over a valid/ready handshake.
- Uses an open-page policy: one row is kept open and reused on row hits.
- Supplies row hit/miss counters for the performance report alongside the L1 cache counters.

Parameters:
- TRP, 5, precharge-to-activate cycles
- TRCD, 5, activate-to-column-command cycles
- TCL, 5, read column command to DRAM_Q valid cycles
- TWR, 5, write column command to next command/ack cycles

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address; bits [22:2] used
- req_wdata  in  32  write data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  read data, valid with resp_valid on reads
- DRAM_CSn  out  1  chip select, active low
- DRAM_RASn  out  1  row strobe, active low
- DRAM_CASn  out  1  column strobe, active low
- DRAM_WEn  out  1  write enable, active low
- DRAM_A  out  11  row or column address
- DRAM_D  out  32  write data
- DRAM_Q  in  32  read data from DRAM
- row_hit_cnt  out  32  accepted requests that hit the open row (wraps)
- row_miss_cnt  out  32  accepted requests needing ACT (wraps)

Interface constraint: one clock; reset is synchronous and active-low. The clock port is clk and the reset port is rst.

Behaviour:
- Reset (rst==0 at a clk edge):
  - DRAM_CSn, RASn, CASn and WEn = 1; DRAM_A = 0; DRAM_D = 0.
  - req_ready = 0; resp_valid = 0; resp_rdata = 0; both counters = 0.
  - Open-row flag cleared; state = IDLE.
  - In-flight work is dropped and no resp_valid is issued for it.
  - req_ready rises in the first cycle after rst returns high.
- Address split:
  - row = req_addr[22:12]
  - col = req_addr[11:2], zero-extended to 11 bits on DRAM_A
- Command encodings (each held exactly one cycle, CSn=0 during the command):
  - PRE: RASn=0, CASn=1, WEn=0
  - ACT: RASn=0, CASn=1, WEn=1, A=row
  - RD: RASn=1, CASn=0, WEn=1, A=col
  - WR: RASn=1, CASn=0, WEn=0, A=col, D=wdata
- Idle/NOP: CSn=RASn=CASn=WEn=1; A and D hold their last values.
- Handshake:
  - req_ready = 1 only in IDLE.
  - Accept when req_valid && req_ready; address, write flag and data are latched.
  - req_ready drops the next cycle and stays low until the cycle after resp_valid.
- States: IDLE, PRE, PRE_W, ACT, ACT_W, RD, RD_W, WR, WR_W, RESP.
  - A wait counter loads T-1 when a command issues. The next command issues exactly T cycles after the previous one.
- Path selection at acceptance:
  - Hit (open && row==open_row): go to RD or WR; row_hit_cnt++.
  - Closed (!open): go to ACT; row_miss_cnt++.
  - Conflict (open && row!=open_row): go to PRE then ACT; row_miss_cnt++.
- Open-row tracking:
  - PRE clears the open flag.
  - ACT sets the open flag and open_row.
- Read completion: DRAM_Q is sampled at the edge ending cycle RD+TCL-1. resp_valid and resp_rdata are asserted in cycle RD+TCL.
- Write completion: resp_valid is asserted in cycle WR+TWR; resp_rdata is unchanged.
- Latency from the accept edge to resp_valid, defaults in brackets:
  - Read hit: TCL+1 [6]
  - Read closed: TRCD+TCL+1 [11]
  - Read conflict: TRP+TRCD+TCL+1 [16]
  - Writes: substitute TWR for TCL.
- Back-to-back: with req_valid held high, the next request is accepted in the cycle after resp_valid. There is a minimum of one idle cycle between responses.
- Counters wrap from 0xFFFF_FFFF to 0. No refresh is issued; the DRAM model does not require it.

Decomposition:
- dram_ctrl_pkg holds:
  - state enum
  - command encoding constants {CSn, RASn, CASn, WEn}
  - ROW_W=11, COL_W=10
  - address bit positions
- Sub-module dram_timer: a loadable down-counter with a done flag, shared by all wait states.

Test Plan:
- Reset values: hold rst=0 for 3 cycles with req_valid=1 → all strobes 1, A=0, req_ready=0, resp_valid=0, counters 0. req_ready=1 in the first cycle after release.
- Read from a closed bank: read 0x0000_1008 with DRAM word 0x402=0xDEAD_BEEF →
  - ACT A=0x001 at t+1
  - RD A=0x002 at t+6
  - resp_valid with 0xDEAD_BEEF at t+11
  - row_miss_cnt=1
- Row hit: read 0x0000_100C immediately after the previous read → RD at t+1, resp_valid at t+6, no ACT, row_hit_cnt=1.
- Row conflict with write: write 0x0000_2000 = 0x1234_5678, then read it back →
  - write: PRE at t+1, ACT A=0x002 at t+6, WR at t+11 with D=0x1234_5678, resp at t+16
  - read-back (hit) returns 0x1234_5678
- Reset mid-operation: assert rst during ACT_W of a read → no resp_valid, open flag cleared. The next read to the same row takes the closed path (11 cycles).
- Back-to-back: req_valid held high for 4 reads in one row → 4 resp_valid pulses, each followed by an accept the next cycle. Counts are hit=3, miss=1.

Source files
------------

// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the open-page DRAM controller.
package dram_ctrl_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ROW_W   = 11;
    localparam int unsigned COL_W   = 10;
    localparam int unsigned A_W     = 11;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned PERF_W  = 32;
    localparam int unsigned ROW_LSB = 12;
    localparam int unsigned COL_LSB = 2;

    typedef enum logic [3:0] {
        ST_IDLE, ST_PRE, ST_PRE_W, ST_ACT, ST_ACT_W,
        ST_RD, ST_RD_W, ST_WR, ST_WR_W, ST_RESP
    } state_t;

    typedef enum logic [1:0] {ISS_NONE, ISS_PRE, ISS_ACT, ISS_COL} issue_t;

    // Command pins packed as {CSn, RASn, CASn, WEn}
    typedef logic [3:0] cmd_t;
    localparam cmd_t CMD_NOP = 4'b1111;
    localparam cmd_t CMD_PRE = 4'b0010;
    localparam cmd_t CMD_ACT = 4'b0011;
    localparam cmd_t CMD_RD  = 4'b0101;
    localparam cmd_t CMD_WR  = 4'b0100;

    typedef struct packed {
        logic              write;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/dram_ctrl_if.sv
// Request/response handshake between the bus wrapper and the DRAM controller.
interface dram_ctrl_if;
    import dram_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/dram_ctrl_timer.sv
// Loadable down-counter shared by every DRAM timing wait.
module dram_timer
    import dram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done_c
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst)              cnt_q <= '0;
        else if (load)         cnt_q <= load_val;
        else if (cnt_q != '0)  cnt_q <= cnt_q - CNT_W'(1);
    end

    assign done_c = (cnt_q == '0);
endmodule

// File: rtl/dram_ctrl.sv
// Open-page DRAM initiator: single-word reads/writes with row hit/miss counters.
module dram_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int unsigned TRP  = 5,
    parameter int unsigned TRCD = 5,
    parameter int unsigned TCL  = 5,
    parameter int unsigned TWR  = 5
)(
    input  logic              clk,
    input  logic              rst,
    dram_ctrl_if.slave        bus,
    output logic              DRAM_CSn,
    output logic              DRAM_RASn,
    output logic              DRAM_CASn,
    output logic              DRAM_WEn,
    output logic [A_W-1:0]    DRAM_A,
    output logic [DATA_W-1:0] DRAM_D,
    input  logic [DATA_W-1:0] DRAM_Q,
    output logic [PERF_W-1:0] row_hit_cnt,
    output logic [PERF_W-1:0] row_miss_cnt
);
    localparam logic [CNT_W-1:0] LD_TRP  = CNT_W'(TRP - 1);
    localparam logic [CNT_W-1:0] LD_TRCD = CNT_W'(TRCD - 1);
    localparam logic [CNT_W-1:0] LD_TCL  = CNT_W'(TCL - 1);
    localparam logic [CNT_W-1:0] LD_TWR  = CNT_W'(TWR - 1);

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [A_W-1:0]    a_q, a_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic              ready_q, ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [PERF_W-1:0] hit_q, hit_d, miss_q, miss_d;
    logic              open_q, open_d;
    logic [ROW_W-1:0]  open_row_q, open_row_d;
    req_t              req_q, req_d, new_req_c, cur_req;
    issue_t            issue;
    logic              tmr_load_c, tmr_done_c;
    logic [CNT_W-1:0]  tmr_val_c;
    logic              unused_addr_bits;

    assign new_req_c = '{write: bus.req_write,
                         row:   bus.req_addr[ROW_LSB +: ROW_W],
                         col:   bus.req_addr[COL_LSB +: COL_W],
                         wdata: bus.req_wdata};
    assign unused_addr_bits = ^{bus.req_addr[ADDR_W-1:ROW_LSB+ROW_W], bus.req_addr[COL_LSB-1:0]};

    dram_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .done_c   (tmr_done_c)
    );

    // Next-state: each state picks which command (if any) goes out next cycle.
    always_comb begin
        state_d      = state_q;
        cmd_d        = CMD_NOP;
        a_d          = a_q;
        d_d          = d_q;
        ready_d      = 1'b0;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        open_d       = open_q;
        open_row_d   = open_row_q;
        req_d        = req_q;
        cur_req      = req_q;
        issue        = ISS_NONE;
        tmr_load_c   = 1'b0;
        tmr_val_c    = '0;

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (bus.req_valid && ready_q) begin
                    ready_d = 1'b0;
                    req_d   = new_req_c;
                    cur_req = new_req_c;
                    if (open_q && (new_req_c.row == open_row_q)) begin
                        hit_d = hit_q + PERF_W'(1);
                        issue = ISS_COL;
                    end else begin
                        miss_d = miss_q + PERF_W'(1);
                        issue  = open_q ? ISS_PRE : ISS_ACT;
                    end
                end
            end
            ST_PRE, ST_PRE_W: if (tmr_done_c) issue = ISS_ACT; else state_d = ST_PRE_W;
            ST_ACT, ST_ACT_W: if (tmr_done_c) issue = ISS_COL; else state_d = ST_ACT_W;
            ST_RD, ST_RD_W: begin
                if (tmr_done_c) begin
                    rdata_d      = DRAM_Q;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    state_d = ST_RD_W;
                end
            end
            ST_WR, ST_WR_W: begin
                if (tmr_done_c) begin
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    state_d = ST_WR_W;
                end
            end
            ST_RESP: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Command issue: drives the pins and arms the timer with T-1.
        case (issue)
            ISS_PRE: begin
                state_d    = ST_PRE;
                cmd_d      = CMD_PRE;
                open_d     = 1'b0;
                tmr_load_c = 1'b1;
                tmr_val_c  = LD_TRP;
            end
            ISS_ACT: begin
                state_d    = ST_ACT;
                cmd_d      = CMD_ACT;
                a_d        = cur_req.row;
                open_d     = 1'b1;
                open_row_d = cur_req.row;
                tmr_load_c = 1'b1;
                tmr_val_c  = LD_TRCD;
            end
            ISS_COL: begin
                a_d        = A_W'(cur_req.col);
                tmr_load_c = 1'b1;
                if (cur_req.write) begin
                    state_d   = ST_WR;
                    cmd_d     = CMD_WR;
                    d_d       = cur_req.wdata;
                    tmr_val_c = LD_TWR;
                end else begin
                    state_d   = ST_RD;
                    cmd_d     = CMD_RD;
                    tmr_val_c = LD_TCL;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= CMD_NOP;
            a_q          <= '0;
            d_q          <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
            open_q       <= 1'b0;
            open_row_q   <= '0;
            req_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            a_q          <= a_d;
            d_q          <= d_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            open_q       <= open_d;
            open_row_q   <= open_row_d;
            req_q        <= req_d;
        end
    end

    assign {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn} = cmd_q;
    assign DRAM_A         = a_q;
    assign DRAM_D         = d_q;
    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign row_hit_cnt    = hit_q;
    assign row_miss_cnt   = miss_q;
endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: DRAM pin model, command log, response scoreboard, vector table.
module tb_dram_ctrl;
    localparam int TCL_P = 5;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam int NV = 9;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
    } vec_t;
    typedef struct { logic [31:0] rdata; int cyc; } sb_t;
    typedef struct { int cyc; logic [3:0] cmd; logic [10:0] a; logic [31:0] d; } cmd_ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn;
    logic [10:0] DRAM_A;
    logic [31:0] DRAM_D;
    logic [31:0] DRAM_Q = 32'h0;
    logic [31:0] row_hit_cnt, row_miss_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int resp_total = 0;
    int last_resp_cyc = -100;

    sb_t         sb[$];
    cmd_ev_t     cmdlog[$];
    logic [31:0] mem [logic [20:0]];
    vec_t        vecs [NV];

    dram_ctrl_if bus ();

    dram_ctrl #(.TRP(5), .TRCD(5), .TCL(TCL_P), .TWR(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .DRAM_CSn     (DRAM_CSn),
        .DRAM_RASn    (DRAM_RASn),
        .DRAM_CASn    (DRAM_CASn),
        .DRAM_WEn     (DRAM_WEn),
        .DRAM_A       (DRAM_A),
        .DRAM_D       (DRAM_D),
        .DRAM_Q       (DRAM_Q),
        .row_hit_cnt  (row_hit_cnt),
        .row_miss_cnt (row_miss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // DRAM model: logs commands, tracks the active row, drives Q only in cycle RD+TCL-1.
    always @(negedge clk) begin : dram_model
        logic [3:0]  c;
        logic [10:0] dm_row;
        logic [20:0] idx;
        logic [31:0] rd_data;
        logic        rd_pend;
        int          rd_cyc;
        c = {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn};
        if (c !== 4'b1111) cmdlog.push_back('{cyc: cyc, cmd: c, a: DRAM_A, d: DRAM_D});
        if (c == C_ACT) dm_row = DRAM_A;
        if (c == C_RD) begin
            idx     = {dm_row, DRAM_A[9:0]};
            rd_data = mem.exists(idx) ? mem[idx] : 32'h0;
            rd_cyc  = cyc;
            rd_pend = 1'b1;
        end
        if (c == C_WR) mem[{dm_row, DRAM_A[9:0]}] = DRAM_D;
        DRAM_Q = (rd_pend === 1'b1 && cyc == rd_cyc + TCL_P - 1) ? rd_data : 32'h0BAD_0BAD;
    end

    // Response monitor: every resp_valid must match the oldest scoreboard entry.
    always @(negedge clk) begin : resp_mon
        sb_t e;
        if (bus.resp_valid === 1'b1) begin
            resp_total++;
            last_resp_cyc = cyc;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got resp_valid at cycle %0d want none", cyc);
            end else begin
                e = sb.pop_front();
                check("resp_cycle", 64'(cyc), 64'(e.cyc));
                check("resp_rdata", 64'(bus.resp_rdata), 64'(e.rdata));
            end
        end
    end

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat, input logic [31:0] exp_rd, output int t_acc);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout: got req_ready=%b want 1 within 100 cycles", bus.req_ready);
            t_acc = -1;
        end else begin
            t_acc = cyc;
            sb.push_back('{rdata: exp_rd, cyc: cyc + lat});
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic check_cmds(input string name, input int t, input int lat, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata);
        cmd_ev_t     exp_q[$];
        cmd_ev_t     ev, got;
        logic [31:0] ad;
        int          col_t;
        ad    = addr;
        col_t = t + lat - TCL_P;
        if (lat > 11) exp_q.push_back('{cyc: t + 1, cmd: C_PRE, a: 11'h0, d: 32'h0});
        if (lat > 6)  exp_q.push_back('{cyc: col_t - 5, cmd: C_ACT, a: ad[22:12], d: 32'h0});
        exp_q.push_back('{cyc: col_t, cmd: wr ? C_WR : C_RD, a: {1'b0, ad[11:2]}, d: wdata});
        foreach (exp_q[i]) begin
            ev = exp_q[i];
            total++;
            if (cmdlog.size() == 0) begin
                bad++;
                $display("FAIL %s_missing_cmd: got no command want cmd %b at cycle %0d", name, ev.cmd, ev.cyc);
            end else begin
                total--;
                got = cmdlog.pop_front();
                check({name, "_cmd_cyc"}, 64'(got.cyc), 64'(ev.cyc));
                check({name, "_cmd"}, 64'(got.cmd), 64'(ev.cmd));
                if (ev.cmd != C_PRE) check({name, "_cmd_a"}, 64'(got.a), 64'(ev.a));
                if (ev.cmd == C_WR)  check({name, "_cmd_d"}, 64'(got.d), 64'(ev.d));
            end
        end
        check({name, "_extra_cmds"}, 64'(cmdlog.size()), 64'd0);
        cmdlog.delete();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish want finish before 40000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t_acc, n, rc0, exp_hit, exp_miss;
        mem[21'h402]    = 32'hDEAD_BEEF;
        mem[21'h403]    = 32'hCAFE_0003;
        mem[21'h1FFFFF] = 32'h7777_8888;
        mem[{11'd5, 10'd1}] = 32'h5555_0001;
        for (int k = 0; k < 4; k++) mem[{11'd3, 10'(k)}] = 32'h3333_0000 + 32'(k);

        vecs[0] = '{1'b0, 32'h0000_1008, 32'h0,          11, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 32'h0000_100C, 32'h0,           6, 32'hCAFE_0003};
        vecs[2] = '{1'b1, 32'h0000_2000, 32'h1234_5678,  16, 32'hCAFE_0003};
        vecs[3] = '{1'b0, 32'h0000_2000, 32'h0,           6, 32'h1234_5678};
        vecs[4] = '{1'b1, 32'h0000_2004, 32'hA5A5_0001,   6, 32'h1234_5678};
        vecs[5] = '{1'b0, 32'h0000_1008, 32'h0,          16, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'h0,          16, 32'h7777_8888};
        vecs[7] = '{1'b1, 32'h007F_FFFC, 32'h0BAD_F00D,   6, 32'h7777_8888};
        vecs[8] = '{1'b0, 32'h007F_FFFC, 32'h0,           6, 32'h0BAD_F00D};

        // Reset held 3 cycles with a request pending.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_1008;
        bus.req_wdata = 32'h0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_strobes", 64'({DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}), 64'hF);
        check("rst_a", 64'(DRAM_A), 64'd0);
        check("rst_d", 64'(DRAM_D), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_rdata", 64'(bus.resp_rdata), 64'd0);
        check("rst_hit", 64'(row_hit_cnt), 64'd0);
        check("rst_miss", 64'(row_miss_cnt), 64'd0);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_ready_rise", 64'(bus.req_ready), 64'd1);
        cmdlog.delete();

        // Vector table: closed, hit, conflict and boundary-address transactions.
        exp_hit  = 0;
        exp_miss = 0;
        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].rdata, t_acc);
            wait_idle($sformatf("vec%0d_drain", i));
            if (t_acc >= 0)
                check_cmds($sformatf("vec%0d", i), t_acc, vecs[i].lat, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].lat == 6) exp_hit++;
            else                  exp_miss++;
        end
        check("tbl_hit_cnt", 64'(row_hit_cnt), 64'(exp_hit));
        check("tbl_miss_cnt", 64'(row_miss_cnt), 64'(exp_miss));

        // Reset during ACT_W of a conflict read: response dropped, row closed.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_5000;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (cmdlog.size() < 2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("midrst_act_seen", 64'(cmdlog.size()), 64'd2);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_hit", 64'(row_hit_cnt), 64'd0);
        check("midrst_miss", 64'(row_miss_cnt), 64'd0);
        rst = 1'b1;
        cmdlog.delete();
        @(negedge clk);
        check("midrst_ready", 64'(bus.req_ready), 64'd1);
        rc0 = resp_total;
        repeat (20) @(negedge clk);
        check("midrst_no_resp", 64'(resp_total - rc0), 64'd0);
        check("midrst_no_cmd", 64'(cmdlog.size()), 64'd0);
        do_req(1'b0, 32'h0000_5004, 32'h0, 11, 32'h5555_0001, t_acc);
        wait_idle("midrst_drain");
        if (t_acc >= 0) check_cmds("midrst_closed", t_acc, 11, 1'b0, 32'h0000_5004, 32'h0);
        check("midrst_miss_after", 64'(row_miss_cnt), 64'd1);

        // Back-to-back reads in one row with req_valid held high, from a fresh reset.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cmdlog.delete();
        rc0 = resp_total;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_3000;
        bus.req_wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (bus.req_ready !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (k > 0) check($sformatf("b2b_accept%0d_gap", k), 64'(cyc), 64'(last_resp_cyc + 1));
            sb.push_back('{rdata: 32'h3333_0000 + 32'(k), cyc: cyc + ((k == 0) ? 11 : 6)});
            @(negedge clk);
            bus.req_addr = 32'h0000_3000 + 32'(4 * (k + 1));
        end
        bus.req_valid = 1'b0;
        wait_idle("b2b_drain");
        check("b2b_resp_count", 64'(resp_total - rc0), 64'd4);
        check("b2b_hit", 64'(row_hit_cnt), 64'd3);
        check("b2b_miss", 64'(row_miss_cnt), 64'd1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
